// File: rtl/vga_display_ctrl.sv
// Raster timing and frame-synchronous digit/colon update controller for the
// six-digit seven-segment VGA clock display.
module vga_display_ctrl #(
    parameter int unsigned PIX_DIV      = 4,
    parameter int unsigned H_TOTAL      = 800,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_ACT_START  = 144,
    parameter int unsigned H_ACT_END    = 784,
    parameter int unsigned V_TOTAL      = 525,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_ACT_START  = 35,
    parameter int unsigned V_ACT_END    = 515,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [41:0] upd_digits,
    input  logic        colon_blink_en,
    output logic [9:0]  horiz_Cnt,
    output logic [9:0]  vert_Cnt,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [6:0]  digit1,
    output logic [6:0]  digit2,
    output logic [6:0]  digit3,
    output logic [6:0]  digit4,
    output logic [6:0]  digit5,
    output logic [6:0]  digit6,
    output logic        colon_on,
    output logic        frame_start
);

    localparam int unsigned CNT_W = 10;
    localparam int unsigned DIG_W = 42;
    localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } upd_state_e;

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             tick;
    logic             h_wrap;
    logic             frame_wrap;
    logic             frame_start_q;

    upd_state_e       state_q;
    logic [DIG_W-1:0] shadow_q;
    logic [DIG_W-1:0] digits_q;

    logic [BLK_W-1:0] blink_cnt_q;
    logic             phase_q;

    assign tick       = (div_q == DIV_W'(PIX_DIV - 1));
    assign h_wrap     = tick && (h_q == CNT_W'(H_TOTAL - 1));
    assign frame_wrap = h_wrap && (v_q == CNT_W'(V_TOTAL - 1));

    // Next-state for the pixel divider and raster counters
    always_comb begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            h_d = h_wrap ? '0 : h_q + CNT_W'(1);
        end
        if (h_wrap) begin
            v_d = (v_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_q + CNT_W'(1);
        end
    end

    // Raster counter registers and the frame-wrap pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            frame_start_q <= frame_wrap;
        end
    end

    // Update handshake: capture into shadow, commit to the decoder at frame wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= '1;
            digits_q <= '1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (upd_valid) begin
                        shadow_q <= upd_digits;
                        state_q  <= PENDING;
                    end
                end
                PENDING: begin
                    if (frame_wrap) begin
                        digits_q <= shadow_q;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Colon blink phase, advanced in whole frames while blinking is enabled
    always_ff @(posedge clk) begin
        if (reset || !colon_blink_en) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else if (frame_wrap) begin
            if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BLK_W'(1);
            end
        end
    end

    // Ready is suppressed during reset so nothing is accepted while state is cleared
    assign upd_ready = (state_q == IDLE) && !reset;

    assign horiz_Cnt   = h_q;
    assign vert_Cnt    = v_q;
    assign hsync       = ~(h_q < CNT_W'(H_SYNC));
    assign vsync       = ~(v_q < CNT_W'(V_SYNC));
    assign video_on    = (h_q >= CNT_W'(H_ACT_START)) && (h_q < CNT_W'(H_ACT_END)) &&
                         (v_q >= CNT_W'(V_ACT_START)) && (v_q < CNT_W'(V_ACT_END));
    assign frame_start = frame_start_q;
    assign colon_on    = ~colon_blink_en | phase_q;

    assign digit1 = digits_q[6:0];
    assign digit2 = digits_q[13:7];
    assign digit3 = digits_q[20:14];
    assign digit4 = digits_q[27:21];
    assign digit5 = digits_q[34:28];
    assign digit6 = digits_q[41:35];

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Randomized bench for vga_display_ctrl with a frame-arithmetic reference model,
// using a scaled-down raster so many frames fit in a short run.
module tb_vga_display_ctrl;

    localparam int unsigned TB_PIX = 2;
    localparam int unsigned TB_HT  = 20;
    localparam int unsigned TB_HS  = 3;
    localparam int unsigned TB_HAS = 5;
    localparam int unsigned TB_HAE = 17;
    localparam int unsigned TB_VT  = 12;
    localparam int unsigned TB_VS  = 2;
    localparam int unsigned TB_VAS = 3;
    localparam int unsigned TB_VAE = 10;
    localparam int unsigned TB_BF  = 3;
    localparam longint      FRAME  = longint'(TB_PIX) * TB_HT * TB_VT;

    logic        clk = 1'b0;
    logic        reset;
    logic        upd_valid;
    logic        upd_ready;
    logic [41:0] upd_digits;
    logic        colon_blink_en;
    logic [9:0]  horiz_Cnt;
    logic [9:0]  vert_Cnt;
    logic        hsync, vsync, video_on;
    logic [6:0]  digit1, digit2, digit3, digit4, digit5, digit6;
    logic        colon_on;
    logic        frame_start;

    int checks   = 0;
    int failures = 0;

    // reference model state
    longint      n_edges = 0;
    logic        pend    = 1'b0;
    logic [41:0] m_dig   = '1;
    logic [41:0] m_shad  = '1;
    int          nb      = 0;
    logic        m_fs    = 1'b0;
    bit          inited  = 1'b0;

    vga_display_ctrl #(
        .PIX_DIV(TB_PIX), .H_TOTAL(TB_HT), .H_SYNC(TB_HS),
        .H_ACT_START(TB_HAS), .H_ACT_END(TB_HAE),
        .V_TOTAL(TB_VT), .V_SYNC(TB_VS),
        .V_ACT_START(TB_VAS), .V_ACT_END(TB_VAE),
        .BLINK_FRAMES(TB_BF)
    ) dut (
        .clk(clk), .reset(reset),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_digits(upd_digits),
        .colon_blink_en(colon_blink_en),
        .horiz_Cnt(horiz_Cnt), .vert_Cnt(vert_Cnt),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .digit4(digit4), .digit5(digit5), .digit6(digit6),
        .colon_on(colon_on), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [41:0] rand_digits();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[41:0];
    endfunction

    // One clock: drive inputs, advance the model at the edge, compare at negedge
    task automatic step(input logic r, input logic v, input logic en, input logic [41:0] d);
        logic   bnd, acc;
        longint k;
        int     h, vv;
        reset          = r;
        upd_valid      = v;
        colon_blink_en = en;
        upd_digits     = d;
        @(posedge clk);
        if (r) begin
            n_edges = 0;
            pend    = 1'b0;
            m_dig   = '1;
            m_shad  = '1;
            nb      = 0;
            m_fs    = 1'b0;
            inited  = 1'b1;
        end else begin
            bnd = ((n_edges + 1) % FRAME) == 0;
            acc = v && !pend;
            if (pend && bnd) begin
                m_dig = m_shad;
                pend  = 1'b0;
            end
            if (acc) begin
                m_shad = d;
                pend   = 1'b1;
            end
            if (!en) nb = 0;
            else if (bnd) nb++;
            n_edges++;
            m_fs = bnd;
        end
        @(negedge clk);
        if (inited) begin
            k  = n_edges / TB_PIX;
            h  = int'(k % TB_HT);
            vv = int'((k / TB_HT) % TB_VT);
            check("horiz_Cnt", 64'(horiz_Cnt), 64'(h));
            check("vert_Cnt", 64'(vert_Cnt), 64'(vv));
            check("hsync", 64'(hsync), 64'(!(h < int'(TB_HS))));
            check("vsync", 64'(vsync), 64'(!(vv < int'(TB_VS))));
            check("video_on", 64'(video_on),
                  64'((h >= int'(TB_HAS)) && (h < int'(TB_HAE)) &&
                      (vv >= int'(TB_VAS)) && (vv < int'(TB_VAE))));
            check("frame_start", 64'(frame_start), 64'(m_fs));
            check("upd_ready", 64'(upd_ready), 64'(!r && !pend));
            check("digits", 64'({digit6, digit5, digit4, digit3, digit2, digit1}), 64'(m_dig));
            check("colon_on", 64'(colon_on), 64'(!en || (((nb / int'(TB_BF)) % 2) == 0)));
        end
    endtask

    initial begin
        logic en_r;
        logic rr;
        reset = 1'b1; upd_valid = 1'b0; colon_blink_en = 1'b0; upd_digits = '0;

        repeat (3) step(1'b1, 1'b0, 1'b0, '0);

        // quiet free-run: raster timing and first frame_start
        repeat (3 * FRAME) step(1'b0, 1'b0, 1'b0, '0);

        // mid-frame update of all zeros, then a different value held while pending
        repeat (FRAME / 2) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, {6{7'h40}});
        repeat (20) step(1'b0, 1'b1, 1'b0, {6{7'h79}});
        repeat (2 * FRAME) step(1'b0, 1'b0, 1'b0, '0);

        // offers only on the frame-boundary tick
        for (int i = 0; i < 4 * FRAME; i++)
            step(1'b0, ((n_edges + 1) % FRAME) == 0, 1'b0, rand_digits());

        // blinking enabled across many frames with random updates, then drop mid-frame
        for (int i = 0; i < 15 * FRAME + FRAME / 3; i++)
            step(1'b0, $urandom_range(0, 15) == 0, 1'b1, rand_digits());
        repeat (50) step(1'b0, 1'b0, 1'b0, '0);

        // fully random traffic with occasional resets and blink toggles
        en_r = 1'b0;
        for (int i = 0; i < 20 * FRAME; i++) begin
            if ($urandom_range(0, 699) == 0) en_r = ~en_r;
            rr = ($urandom_range(0, 999) == 0);
            step(rr, $urandom_range(0, 7) == 0, en_r, rand_digits());
        end

        // reset while an update is pending: data must never appear
        repeat (FRAME / 3) step(1'b0, 1'b0, 1'b0, '0);
        while (pend) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, {6{7'h12}});
        repeat (10) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        repeat (2 * FRAME + 5) step(1'b0, 1'b0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
